// File: rtl/count_pkg.sv
// Shared types and defaults for the counter command sequencer.
package count_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 10;

  typedef enum logic [1:0] {OP_NOP, OP_LOAD, OP_UP, OP_DOWN} cmd_op_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} ctrl_state_t;

endpackage

// File: rtl/count_prescaler.sv
// Free-running 0..PRESC_DIV-1 counter with synchronous clear; tick_o marks the terminal count.
module count_prescaler #(
  parameter int unsigned PRESC_DIV = 5000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESC_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr_i || cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/count_cmd_ctrl.sv
// Command sequencer driving the up/down counter: one load pulse or N prescaled step pulses.
// Optional abort input in RUN enabled by defining COUNT_CTRL_ABORT_EN.
module count_cmd_ctrl
  import count_pkg::*;
#(
  parameter int unsigned WIDTH     = CNT_WIDTH_DEF,
  parameter int unsigned PRESC_DIV = 5000
) (
  input  logic             clk5m,
  input  logic             rst_n,
`ifdef COUNT_CTRL_ABORT_EN
  input  logic             abort,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic             en,
  output logic             load,
  output logic             updn,
  output logic [WIDTH-1:0] data_out,
  output logic             busy,
  output logic             done
);

  ctrl_state_t      state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             updn_q, updn_d;
  logic             tick, presc_clr, abort_w;
  cmd_op_t          op;

`ifdef COUNT_CTRL_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign op        = cmd_op_t'(cmd_op);
  assign presc_clr = (state_q == S_IDLE) && cmd_valid;

  count_prescaler #(.PRESC_DIV(PRESC_DIV)) u_presc (
    .clk_i  (clk5m),
    .rst_ni (rst_n),
    .clr_i  (presc_clr),
    .tick_o (tick)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    data_d  = data_q;
    updn_d  = updn_q;
    en      = 1'b0;
    load    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          case (op)
            OP_NOP:  state_d = S_DONE;
            OP_LOAD: begin
              state_d = S_LOAD;
              data_d  = cmd_arg;
            end
            default: begin
              state_d = S_RUN;
              updn_d  = cmd_op[0];
              rem_d   = cmd_arg;
            end
          endcase
        end
      end
      S_LOAD: begin
        en      = 1'b1;
        load    = 1'b1;
        state_d = S_DONE;
      end
      S_RUN: begin
        // Leaving on the last pulse (not one cycle later) puts done right after the final step.
        if (abort_w || rem_q == '0) begin
          state_d = S_DONE;
        end else if (tick) begin
          en    = 1'b1;
          rem_d = rem_q - WIDTH'(1);
          if (rem_q == WIDTH'(1)) state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk5m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      data_q  <= '0;
      updn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      data_q  <= data_d;
      updn_q  <= updn_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign updn      = updn_q;
  assign data_out  = data_q;

endmodule
